main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multicycle main control unit for the MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, including the 2-bit `alu_op` consumed by the ALU control decoder. Memory accesses use a `mem_ready` handshake, and the unit keeps a retired-instruction counter.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 6: instruction bits [31:26] from the IR; sampled only in DECODE.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `iord` output 1: 0 = PC addresses memory, 1 = ALUOut addresses memory.
- `ir_write` output 1: IR load enable.
- `pc_write` output 1: unconditional PC write.
- `branch` output 1: conditional PC write, qualified by ALU zero outside this block.
- `pc_src` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `reg_write` output 1: register file write enable.
- `reg_dst` output 1: 1 = rd, 0 = rt.
- `mem_to_reg` output 1: 1 = MDR, 0 = ALUOut.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `alu_op` output 2: 00 = add, 01 = subtract, 10 = use funct. 11 is never driven.
- `illegal_op` output 1: one-cycle pulse for an unsupported opcode.
- `state` output 4: current state code, for debug.
- `retired` output `RETIRE_W`: count of completed instructions.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, the next state is FETCH.
- Outputs are decoded from `state`. The only exceptions are the memory-completion strobes, which are gated by `mem_ready`. Unlisted outputs are 0.
- FETCH
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Advances to DECODE when `mem_ready`=1; otherwise holds.
- DECODE
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - Next state by opcode: 100011 (lw) and 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP.
  - Any other opcode -> FETCH, with `illegal_op`=1 for this cycle.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next is MEMRD for lw, MEMWR for sw. The opcode is re-read here; the IR is stable.
- MEMRD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next is FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Holds until `mem_ready`, then goes to FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next is ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next is FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `branch`=1, `pc_src`=01. Next is FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next is ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next is FETCH.
- JUMP: `pc_write`=1, `pc_src`=10. Next is FETCH.
- Retirement: `retired` increments by 1 on the clock edge leaving a final state.
  - Final states are MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, and MEMWR when `mem_ready`=1.
  - Illegal opcodes do not retire.
  - The counter wraps modulo 2^`RETIRE_W`.

## Timing
- Reset, while `rst`=1 and asynchronously on assertion:
  - `state`=FETCH and `retired`=0.
  - All write and request strobes are forced to 0: `mem_read`, `mem_write`, `ir_write`, `pc_write`, `branch`, `reg_write`.
  - Select outputs take their FETCH values: `alu_src_b`=01, `alu_op`=00, all others 0. `illegal_op`=0.
- First fetch begins the cycle after `rst` deasserts.
- Reset asserted mid-instruction aborts it. No strobe is issued after the assertion, and the aborted instruction does not retire.
- Zero-wait latencies, counted in cycles from FETCH entry to next FETCH entry: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Request outputs stay asserted and stable throughout a stall.
- `mem_ready` is ignored in all other states.
- `opcode` changes outside DECODE and MEMADR have no effect.

## Test plan
- Reset: assert `rst` mid-MEMRD -> `state`=0, `mem_read`=0 during reset, `retired`=0. After release, FETCH asserts `mem_read`=1.
- lw (opcode 100011), `mem_ready` tied 1 -> state sequence 0,1,2,3,4,0. `reg_write`=1 with `mem_to_reg`=1 only in state 4. `retired` goes 0->1.
- R-type (000000) -> `alu_op`=10 in EXECUTE. ALUWB drives `reg_dst`=1. beq (000100) -> `alu_op`=01 and `branch`=1 in the single BRANCH cycle. No cycle shows `alu_op`=11.
- sw with `mem_ready`=0 for 3 cycles in MEMWR -> `mem_write`=1 held 4 cycles, then FETCH. `retired` increments once.
- FETCH with `mem_ready` low 2 cycles -> `ir_write`=0 and `pc_write`=0 for 2 cycles, then 1 for one cycle, then DECODE.
- Opcode 111111 -> `illegal_op`=1 for one cycle in DECODE, next state 0, `retired` unchanged. A following j (000010) -> JUMP drives `pc_src`=10 and `pc_write`=1.

Source files
------------

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_control_fsm
// Brief    : Multicycle MIPS main control: opcode-driven state sequencer with
//            mem_ready handshake and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module main_control_fsm #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          opcode,
   input  logic                mem_ready,
   output logic                mem_read,
   output logic                mem_write,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic                branch,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic                illegal_op,
   output logic [3:0]          state,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_J     = 6'b000010;

   state_t              r_state;
   state_t              w_next;
   logic                w_retire;
   logic [RETIRE_W-1:0] r_retired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire)
            r_retired <= r_retired + 1'b1;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      pc_src     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      illegal_op = 1'b0;

      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready)
               w_next = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               c_OP_LW, c_OP_SW: w_next = S_MEMADR;
               c_OP_RTYPE:       w_next = S_EXECUTE;
               c_OP_BEQ:         w_next = S_BRANCH;
               c_OP_ADDI:        w_next = S_ADDIEX;
               c_OP_J:           w_next = S_JUMP;
               default: begin
                  w_next     = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready)
               w_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            w_next     = S_FETCH;
            w_retire   = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            branch    = 1'b1;
            pc_src    = 2'b01;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase

      // The state register is already FETCH under reset; suppress its strobes.
      if (rst) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         branch     = 1'b0;
         reg_write  = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_control_fsm
// Brief    : Scoreboard bench for main_control_fsm instruction sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = 6'd0;
   logic        mem_ready = 1'b0;
   logic        mem_read, mem_write, iord, ir_write, pc_write, branch;
   logic [1:0]  pc_src;
   logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0]  alu_src_b, alu_op;
   logic        illegal_op;
   logic [3:0]  state;
   logic [31:0] retired;

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] ctl;
      logic [31:0] ret;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_cyc = 0;

   main_control_fsm #(.RETIRE_W(32)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
      .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .illegal_op(illegal_op), .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Control word expected for a state, from the output table of the unit.
   function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic rdy,
                                           input logic ill, input logic in_rst);
      logic       mr, mw, io, irw, pcw, br, rw, rd, m2r, a, il;
      logic [1:0] pcs, b, op;
      {mr, mw, io, irw, pcw, br, rw, rd, m2r, a, il} = '0;
      {pcs, b, op} = '0;
      if (in_rst) begin
         b = 2'b01;
      end else begin
         case (st)
            4'd0:  begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  begin b = 2'b11; il = ill; end
            4'd2:  begin a = 1; b = 2'b10; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin a = 1; op = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin a = 1; op = 2'b01; br = 1; pcs = 2'b01; end
            4'd9:  begin a = 1; b = 2'b10; end
            4'd10: begin rw = 1; end
            4'd11: begin pcw = 1; pcs = 2'b10; end
            default: ;
         endcase
      end
      return {mr, mw, io, irw, pcw, br, pcs, rw, rd, m2r, a, b, op, il};
   endfunction

   // One clock period: drive inputs, queue the expectation, then check outputs.
   task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] est, input logic ill, input int eret);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst       = r;
      opcode    = op;
      mem_ready = rdy;
      sb.push_back('{st: est, ctl: exp_ctl(est, rdy, ill, r), ret: eret});
      #1;
      n_cyc++;
      e   = sb.pop_front();
      got = '{st: state,
              ctl: {mem_read, mem_write, iord, ir_write, pc_write, branch, pc_src,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    illegal_op},
              ret: retired};
      chk($sformatf("state c%0d", n_cyc), {28'd0, got.st}, {28'd0, e.st});
      chk($sformatf("ctl c%0d", n_cyc), {15'd0, got.ctl}, {15'd0, e.ctl});
      chk($sformatf("retired c%0d", n_cyc), got.ret, e.ret);
      chk($sformatf("alu_op11 c%0d", n_cyc), {31'd0, alu_op == 2'b11}, 32'd0);
   endtask

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   initial begin
      cyc(1, LW, 1, 0, 0, 0);
      cyc(1, LW, 1, 0, 0, 0);
      // lw, zero wait
      cyc(0, LW, 1, 0, 0, 0);
      cyc(0, LW, 1, 1, 0, 0);
      cyc(0, LW, 1, 2, 0, 0);
      cyc(0, LW, 1, 3, 0, 0);
      cyc(0, LW, 1, 4, 0, 0);
      // R-type; opcode flips during EXECUTE without effect
      cyc(0, RT, 1, 0, 0, 1);
      cyc(0, RT, 1, 1, 0, 1);
      cyc(0, LW, 1, 6, 0, 1);
      cyc(0, LW, 1, 7, 0, 1);
      // beq
      cyc(0, BEQ, 1, 0, 0, 2);
      cyc(0, BEQ, 1, 1, 0, 2);
      cyc(0, BEQ, 0, 8, 0, 2);
      // addi
      cyc(0, ADDI, 1, 0, 0, 3);
      cyc(0, ADDI, 1, 1, 0, 3);
      cyc(0, ADDI, 0, 9, 0, 3);
      cyc(0, ADDI, 0, 10, 0, 3);
      // sw with three stall cycles in MEMWR
      cyc(0, SW, 1, 0, 0, 4);
      cyc(0, SW, 1, 1, 0, 4);
      cyc(0, SW, 1, 2, 0, 4);
      cyc(0, SW, 0, 5, 0, 4);
      cyc(0, SW, 0, 5, 0, 4);
      cyc(0, SW, 0, 5, 0, 4);
      cyc(0, SW, 1, 5, 0, 4);
      // FETCH stalled two cycles, then an illegal opcode
      cyc(0, BAD, 0, 0, 0, 5);
      cyc(0, BAD, 0, 0, 0, 5);
      cyc(0, BAD, 1, 0, 0, 5);
      cyc(0, BAD, 1, 1, 1, 5);
      // j after the illegal opcode
      cyc(0, J, 1, 0, 0, 5);
      cyc(0, J, 1, 1, 0, 5);
      cyc(0, J, 1, 11, 0, 5);
      // lw aborted by reset while stalled in MEMRD
      cyc(0, LW, 1, 0, 0, 6);
      cyc(0, LW, 1, 1, 0, 6);
      cyc(0, LW, 1, 2, 0, 6);
      cyc(0, LW, 0, 3, 0, 6);
      cyc(1, LW, 1, 0, 0, 0);
      cyc(1, LW, 1, 0, 0, 0);
      cyc(0, LW, 0, 0, 0, 0);
      cyc(0, LW, 1, 0, 0, 0);
      cyc(0, LW, 1, 1, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
